odyssey_video_timing: RTL and testbench



---
 rtl/odyssey_video_pkg.sv | 35 +++
 rtl/odyssey_axis_timer.sv | 50 +++++
 rtl/odyssey_video_timing.sv | 184 ++++++++++++++++++
 tb/tb_odyssey_video_timing.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/odyssey_video_pkg.sv
// Shared timing constants, counter widths and vertical state encoding for the
// Odyssey video timing generator.
// Ports: none (package).
package odyssey_video_pkg;

  // Default raster: 1270-clock lines, 262-line progressive frames.
  localparam int DEF_H_TOTAL     = 1270;
  localparam int DEF_H_SYNC_LEN  = 94;
  localparam int DEF_H_ACT_START = 88;
  localparam int DEF_H_ACT_END   = 1147;
  localparam int DEF_V_TOTAL     = 262;
  localparam int DEF_V_SYNC_LEN  = 3;
  localparam int DEF_V_ACT_START = 34;
  localparam int DEF_V_ACT_END   = 240;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 9;

  typedef enum logic [1:0] {
    V_ACTIVE,
    V_FRONT,
    V_SYNC,
    V_BACK
  } vstate_t;

  // Active window must end before the sync window, and the largest count
  // value must fit the counter.
  function automatic bit axis_timing_ok(int total, int sync_len, int act_start,
                                        int act_end, int cnt_w);
    return (act_start >= 0) && (act_start < act_end) &&
           (act_end <= total - sync_len) && (sync_len > 0) &&
           (total < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/odyssey_axis_timer.sv
// Generic wrap counter for one raster axis, with sync and active windows.
// Latency: count registered; cnt_d/wrap/sync_d/act_d describe the next count.
// Backpressure: none; advances only when step=1, wraps to 0 after 'last'.
// Ports: clk, reset (async, active-high), step (advance), last (wrap value),
//        cnt_q (current count), cnt_d (next count), wrap (step at last),
//        sync_d (next count >= SYNC_START), act_d (next count in active window).
module odyssey_axis_timer #(
  parameter int W          = 11,
  parameter int SYNC_START = 1,
  parameter int ACT_START  = 1,
  parameter int ACT_END    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d,
  output logic         wrap,
  output logic         sync_d,
  output logic         act_d
);

  localparam logic [W-1:0] SYNC_C  = W'(SYNC_START);
  localparam logic [W-1:0] ACT_S_C = W'(ACT_START);
  localparam logic [W-1:0] ACT_E_C = W'(ACT_END);

  always_comb begin
    wrap  = step && (cnt_q == last);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Windows are evaluated on the next count so the registered flags line
    // up with the registered count.
    sync_d = (cnt_d >= SYNC_C);
    act_d  = (cnt_d >= ACT_S_C) && (cnt_d < ACT_E_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/odyssey_video_timing.sv
// Odyssey video timing generator: HSync/VSync, HBlank/VBlank, counters, strobes.
// Latency: all outputs registered and consistent with the hcount/vcount shown.
// Backpressure: none; every flop holds while ce=0, strobes last one clk.
// Optional feature macro: ODYSSEY_TIMING_INTERLACE_EN (alternating fields,
// odd field one line longer with VSync shifted by half a line).
// Ports: clk, reset (async, active-high), ce (pixel enable),
//        hcount/vcount (raster position), HSync/VSync (active-high syncs),
//        HBlank/VBlank, line_start/frame_start (one-clk strobes), field.
module odyssey_video_timing
  import odyssey_video_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC_LEN  = DEF_H_SYNC_LEN,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_END   = DEF_H_ACT_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC_LEN  = DEF_V_SYNC_LEN,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT_END   = DEF_V_ACT_END
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              line_start,
  output logic              frame_start,
  output logic              field
);

  if (!axis_timing_ok(H_TOTAL, H_SYNC_LEN, H_ACT_START, H_ACT_END, HCNT_W) ||
      !axis_timing_ok(V_TOTAL, V_SYNC_LEN, V_ACT_START, V_ACT_END, VCNT_W)) begin : g_bad_timing
    $error("odyssey_video_timing: illegal timing parameters");
  end

  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic              h_wrap, h_sync_d, h_act_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d, v_last;
  logic              v_wrap, v_sync_d, v_act_d;

  vstate_t state_q, state_d;
  logic    field_q, field_d;
  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  logic    hblank_q, hblank_d;
  logic    vblank_q, vblank_d;
  logic    line_start_q, line_start_d;
  logic    frame_start_q, frame_start_d;

  odyssey_axis_timer #(
    .W         (HCNT_W),
    .SYNC_START(H_TOTAL - H_SYNC_LEN),
    .ACT_START (H_ACT_START),
    .ACT_END   (H_ACT_END)
  ) u_htimer (
    .clk   (clk),
    .reset (reset),
    .step  (ce),
    .last  (HCNT_W'(H_TOTAL - 1)),
    .cnt_q (h_cnt_q),
    .cnt_d (h_cnt_d),
    .wrap  (h_wrap),
    .sync_d(h_sync_d),
    .act_d (h_act_d)
  );

  // The vertical axis steps on the same clock the line wraps, so every
  // vertical output changes together with the HSync falling edge.
  odyssey_axis_timer #(
    .W         (VCNT_W),
    .SYNC_START(V_TOTAL - V_SYNC_LEN),
    .ACT_START (V_ACT_START),
    .ACT_END   (V_ACT_END)
  ) u_vtimer (
    .clk   (clk),
    .reset (reset),
    .step  (h_wrap),
    .last  (v_last),
    .cnt_q (v_cnt_q),
    .cnt_d (v_cnt_d),
    .wrap  (v_wrap),
    .sync_d(v_sync_d),
    .act_d (v_act_d)
  );

`ifdef ODYSSEY_TIMING_INTERLACE_EN
  localparam logic [HCNT_W-1:0] H_HALF   = HCNT_W'(H_TOTAL / 2);
  localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_TOTAL - V_SYNC_LEN);
  localparam logic [VCNT_W-1:0] V_EXTRA  = VCNT_W'(V_TOTAL);

  // Field 1 carries one extra line (vcount reaches V_TOTAL).
  always_comb begin
    field_d = field_q ^ v_wrap;
    v_last  = field_q ? VCNT_W'(V_TOTAL) : VCNT_W'(V_TOTAL - 1);
  end
`else
  always_comb begin
    field_d = 1'b0;
    v_last  = VCNT_W'(V_TOTAL - 1);
  end
`endif

  // Vertical FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= V_BACK;
    end else begin
      state_q <= state_d;
    end
  end

  // Vertical FSM: next state, judged on the line count being entered.
  always_comb begin
    state_d = state_q;
    if (h_wrap) begin
      unique case (state_q)
        V_BACK:   if (v_act_d) state_d = V_ACTIVE;
        V_ACTIVE: begin
          if (v_sync_d)      state_d = V_SYNC;
          else if (!v_act_d) state_d = V_FRONT;
        end
        V_FRONT:  if (v_sync_d) state_d = V_SYNC;
        V_SYNC:   if (v_cnt_d == '0) state_d = v_act_d ? V_ACTIVE : V_BACK;
        default:  state_d = V_BACK;
      endcase
    end
  end

  // Vertical FSM: outputs, taken from the next state so they register
  // alongside the vcount they describe.
  always_comb begin
    vsync_d  = (state_d == V_SYNC);
    vblank_d = (state_d != V_ACTIVE);
`ifdef ODYSSEY_TIMING_INTERLACE_EN
    // Odd field: same sync length, shifted by half a line.
    if (field_d) begin
      vsync_d = ((v_cnt_d > VS_START) || ((v_cnt_d == VS_START) && (h_cnt_d >= H_HALF))) &&
                !((v_cnt_d == V_EXTRA) && (h_cnt_d >= H_HALF));
    end
`endif
  end

  always_comb begin
    hsync_d       = h_sync_d;
    hblank_d      = ~h_act_d;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      field_q       <= field_d;
    end
  end

  assign hcount      = h_cnt_q;
  assign vcount      = v_cnt_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign field       = field_q;

endmodule

// File: tb/tb_odyssey_video_timing.sv
// Bench for odyssey_video_timing: a full-size instance for line-level timing
// and a small-raster instance so whole frames fit in a short run. A reference
// model predicts both instances every clock; predictions are queued when the
// inputs are driven and compared once the clock edge has produced outputs.
module tb_odyssey_video_timing;

  localparam int S_HT = 20, S_HSL = 3, S_HAS = 4, S_HAE = 15;
  localparam int S_VT = 12, S_VSL = 2, S_VAS = 3, S_VAE = 9;
`ifdef ODYSSEY_TIMING_INTERLACE_EN
  localparam bit ILACE = 1'b1;
`else
  localparam bit ILACE = 1'b0;
`endif

  typedef struct {
    int ht, hsl, has, hae, vt, vsl, vas, vae;
  } cfg_t;

  typedef struct {
    int hc, vc, fld;
    bit hs, vs, hb, vb, ls, fs;
  } mst_t;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [10:0] d_hc, s_hc;
  logic [8:0]  d_vc, s_vc;
  logic d_hs, d_vs, d_hb, d_vb, d_ls, d_fs, d_fld;
  logic s_hs, s_vs, s_hb, s_vb, s_ls, s_fs, s_fld;
  logic [31:0] d_pack, s_pack;

  assign d_pack = {5'b0, d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_ls, d_fs, d_fld};
  assign s_pack = {5'b0, s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_ls, s_fs, s_fld};

  always #5 clk = ~clk;

  odyssey_video_timing u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hcount(d_hc), .vcount(d_vc), .HSync(d_hs), .VSync(d_vs),
    .HBlank(d_hb), .VBlank(d_vb), .line_start(d_ls), .frame_start(d_fs),
    .field(d_fld)
  );

  odyssey_video_timing #(
    .H_TOTAL(S_HT), .H_SYNC_LEN(S_HSL), .H_ACT_START(S_HAS), .H_ACT_END(S_HAE),
    .V_TOTAL(S_VT), .V_SYNC_LEN(S_VSL), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
  ) u_small (
    .clk(clk), .reset(reset), .ce(ce),
    .hcount(s_hc), .vcount(s_vc), .HSync(s_hs), .VSync(s_vs),
    .HBlank(s_hb), .VBlank(s_vb), .line_start(s_ls), .frame_start(s_fs),
    .field(s_fld)
  );

  int n_tests = 0;
  int n_fail  = 0;
  cfg_t cfg_d, cfg_s;
  mst_t md, ms;
  logic [31:0] q_d[$];
  logic [31:0] q_s[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic mst_t reset_state();
    mst_t r;
    r.hc = 0; r.vc = 0; r.fld = 0;
    r.hs = 0; r.vs = 0; r.hb = 1; r.vb = 1; r.ls = 0; r.fs = 0;
    return r;
  endfunction

  // Raster position after one clock, outputs derived from window definitions.
  function automatic mst_t model_next(cfg_t c, mst_t s, bit ce_v);
    mst_t n;
    int lastv, half, p;
    n = s;
    n.ls = 0;
    n.fs = 0;
    lastv = c.vt - 1 + (ILACE ? s.fld : 0);
    if (ce_v) begin
      if (s.hc == c.ht - 1) begin
        n.hc = 0;
        n.ls = 1;
        if (s.vc == lastv) begin
          n.vc = 0;
          n.fs = 1;
          if (ILACE) n.fld = 1 - s.fld;
        end else begin
          n.vc = s.vc + 1;
        end
      end else begin
        n.hc = s.hc + 1;
      end
    end
    n.hs = (n.hc >= c.ht - c.hsl);
    n.hb = !((n.hc >= c.has) && (n.hc < c.hae));
    n.vb = !((n.vc >= c.vas) && (n.vc < c.vae));
    half = c.ht / 2;
    p = n.vc * c.ht + n.hc;
    if (n.fld == 1) n.vs = (p >= (c.vt - c.vsl) * c.ht + half) && (p < c.vt * c.ht + half);
    else            n.vs = (n.vc >= c.vt - c.vsl);
    return n;
  endfunction

  function automatic logic [31:0] pack_m(mst_t m);
    return {5'b0, 11'(m.hc), 9'(m.vc), m.hs, m.vs, m.hb, m.vb, m.ls, m.fs, 1'(m.fld)};
  endfunction

  // Drive one clock of stimulus, queue the prediction, then compare.
  task automatic tick(input bit ce_v);
    ce = ce_v;
    if (reset) begin
      md = reset_state();
      ms = reset_state();
    end else begin
      md = model_next(cfg_d, md, ce_v);
      ms = model_next(cfg_s, ms, ce_v);
    end
    q_d.push_back(pack_m(md));
    q_s.push_back(pack_m(ms));
    @(posedge clk);
    #1;
    chk("def_outs", d_pack, q_d.pop_front());
    chk("small_outs", s_pack, q_s.pop_front());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_hb, n_ls, hb_fall, first_ls, last_ls;
    int lines, act, vsl_lines, ticks, n_edges;
    bit found;
    logic fld, prev_fld, prev_vs;

    cfg_d = '{1270, 94, 88, 1147, 262, 3, 34, 240};
    cfg_s = '{S_HT, S_HSL, S_HAS, S_HAE, S_VT, S_VSL, S_VAS, S_VAE};
    md = reset_state();
    ms = reset_state();
    prev_fld = 1'b0;
    reset = 1'b1;
    ce = 1'b1;

    // Reset held with ce=1: everything parked at reset values.
    repeat (5) tick(1'b1);
    chk("rst_hblank", 32'(d_hb), 32'd1);
    chk("rst_vblank", 32'(d_vb), 32'd1);

    // First line after release: blank ends at 88, sync rises at 1176.
    reset = 1'b0;
    found = 1'b0;
    hb_fall = -1;
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1);
      if (!d_hb && hb_fall < 0) hb_fall = 32'(d_hc);
      if (d_hs) begin
        found = 1'b1;
        break;
      end
    end
    chk("hs_rise_found", 32'(found), 32'd1);
    chk("hs_rise_hc", 32'(d_hc), 32'd1176);
    chk("hb_fall_hc", hb_fall, 32'd88);

    n = 1;
    for (int i = 0; i < 200 && d_hs; i++) begin
      tick(1'b1);
      if (d_hs) n++;
    end
    chk("hs_width", n, 32'd94);
    chk("hs_fall_ls", 32'(d_ls), 32'd1);
    chk("hs_fall_hc", 32'(d_hc), 32'd0);

    // One full line from hcount=0.
    n_hb = 0;
    n_ls = 0;
    for (int i = 0; i < 1270; i++) begin
      tick(1'b1);
      if (!d_hb) n_hb++;
      if (d_ls) n_ls++;
    end
    chk("hblank_low_len", n_hb, 32'd1059);
    chk("line_ls_count", n_ls, 32'd1);
    chk("line_end_ls", 32'(d_ls), 32'd1);

    // ce every other clock: intervals double, strobes stay one clk.
    n_ls = 0;
    first_ls = -1;
    last_ls = -1;
    for (int i = 0; i < 5080; i++) begin
      tick(i % 2 == 0);
      if (d_ls) begin
        n_ls++;
        if (first_ls < 0) first_ls = i;
        else last_ls = i;
      end
    end
    chk("ce_half_ls_count", n_ls, 32'd2);
    chk("ce_half_first_ls", first_ls, 32'd2538);
    chk("ce_half_period", last_ls - first_ls, 32'd2540);

    // Small raster: align on frame_start, then measure whole frames.
    for (int i = 0; i < 800; i++) begin
      tick(1'b1);
      if (s_fs) break;
    end
    chk("small_align_fs", 32'(s_fs), 32'd1);
    chk("small_align_vc", 32'(s_vc), 32'd0);
    for (int f = 0; f < 3; f++) begin
      fld = s_fld;
      if (f > 0) chk("field_seq", 32'(fld), ILACE ? 32'(!prev_fld) : 32'd0);
      lines = 0; act = 0; vsl_lines = 0; ticks = 0; n_edges = 0;
      prev_vs = s_vs;
      for (int j = 0; j < 1000; j++) begin
        tick(1'b1);
        ticks++;
        if (s_vs !== prev_vs) begin
          n_edges++;
          chk("vs_edge_hc", 32'(s_hc), fld ? 32'(S_HT / 2) : 32'd0);
          prev_vs = s_vs;
        end
        if (s_ls) begin
          lines++;
          if (!s_vb) act++;
          if (s_vs) vsl_lines++;
        end
        if (s_fs) break;
      end
      chk("frame_clocks", ticks, 32'((S_VT + 32'(fld)) * S_HT));
      chk("frame_lines", lines, 32'(S_VT + 32'(fld)));
      chk("vactive_lines", act, 32'(S_VAE - S_VAS));
      chk("vsync_lines", vsl_lines, 32'(S_VSL));
      chk("vsync_edges", n_edges, 32'd2);
      prev_fld = fld;
    end

    // Asynchronous reset mid-line / mid-frame.
    for (int i = 0; i < 1300; i++) begin
      tick(1'b1);
      if (d_hc == 11'd600) break;
    end
    chk("pre_rst_hc", 32'(d_hc), 32'd600);
    reset = 1'b1;
    #2;
    chk("async_rst_def", d_pack, pack_m(reset_state()));
    chk("async_rst_small", s_pack, pack_m(reset_state()));
    repeat (3) tick(1'b1);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 1400; i++) begin
      tick(1'b1);
      n++;
      if (d_ls) break;
    end
    chk("post_rst_line_len", n, 32'd1270);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
